// File: rtl/reg_bank_ctrl.sv
// Configuration register bank shared by the SPI slave and a core requester.
// SPI writes have priority, core accesses use req/gnt, and fast commands drive clear/lock/status.
module reg_bank_ctrl #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [ADDR_W-1:0]                spi_addr,
  input  logic [REG_W-1:0]                 spi_wdata,
  input  logic                             spi_wvld,
  output logic [REG_W-1:0]                 spi_rdata,
  input  logic [5:0]                       fastcmd,
  input  logic                             fastcmd_vld,
  output logic [7:0]                       status,
  input  logic                             core_req,
  input  logic                             core_we,
  input  logic [ADDR_W-1:0]                core_addr,
  input  logic [REG_W-1:0]                 core_wdata,
  output logic                             core_gnt,
  output logic [REG_W-1:0]                 core_rdata,
  output logic                             core_rvld,
  output logic [(2**ADDR_W)*REG_W-1:0]     regs_flat
);

  localparam int         DEPTH     = 2**ADDR_W;
  localparam logic [5:0] CMD_CLEAR = 6'h01;
  localparam logic [5:0] CMD_LOCK  = 6'h02;
  localparam logic [5:0] CMD_UNLCK = 6'h03;
  localparam logic [5:0] CMD_CLRST = 6'h04;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   w_clr_ptr_nxt;
  logic [REG_W-1:0]    r_bank [DEPTH];
  logic                r_lock;
  logic                r_drop;
  logic [3:0]          r_coll;
  logic [REG_W-1:0]    r_core_rdata;
  logic                r_core_rvld;

  logic w_cmd_clear;
  logic w_cmd_lock;
  logic w_cmd_unlock;
  logic w_cmd_clrst;
  logic w_busy;
  logic w_gnt;
  logic w_ptr_last;
  logic w_collision;

  assign w_cmd_clear  = fastcmd_vld & (fastcmd == CMD_CLEAR);
  assign w_cmd_lock   = fastcmd_vld & (fastcmd == CMD_LOCK);
  assign w_cmd_unlock = fastcmd_vld & (fastcmd == CMD_UNLCK);
  assign w_cmd_clrst  = fastcmd_vld & (fastcmd == CMD_CLRST);
  assign w_busy       = (r_state == ST_CLEAR);
  assign w_gnt        = core_req & ~w_busy & ~spi_wvld;
  assign w_ptr_last   = (r_clr_ptr == {ADDR_W{1'b1}});
  assign w_collision  = core_req & spi_wvld;

  // State and clear-pointer registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_clr_ptr <= {ADDR_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // Next-state logic; a clear command in CLEAR restarts the sweep from address 0
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_clear) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_ptr_nxt = {ADDR_W{1'b0}};
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (w_cmd_clear) begin
          w_clr_ptr_nxt = {ADDR_W{1'b0}};
        end else if (w_ptr_last) begin
          w_state_nxt   = ST_IDLE;
          w_clr_ptr_nxt = {ADDR_W{1'b0}};
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_clr_ptr_nxt = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Register bank: clear sweep, then SPI write, then granted core write
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bank[i] <= {REG_W{1'b0}};
      end
    end else if (w_busy) begin
      r_bank[r_clr_ptr] <= {REG_W{1'b0}};
    end else if (spi_wvld) begin
      r_bank[spi_addr] <= spi_wdata;
    end else if (w_gnt & core_we & ~r_lock) begin
      r_bank[core_addr] <= core_wdata;
    end
  end

  // Core read return path
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_core_rdata <= {REG_W{1'b0}};
      r_core_rvld  <= 1'b0;
    end else begin
      r_core_rvld <= w_gnt & ~core_we;
      if (w_gnt & ~core_we) begin
        r_core_rdata <= r_bank[core_addr];
      end
    end
  end

  // Lock, sticky drop flag and saturating collision counter; clear-status wins
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lock <= 1'b0;
      r_drop <= 1'b0;
      r_coll <= 4'd0;
    end else begin
      if (w_cmd_lock) begin
        r_lock <= 1'b1;
      end else if (w_cmd_unlock) begin
        r_lock <= 1'b0;
      end
      if (w_cmd_clrst) begin
        r_drop <= 1'b0;
        r_coll <= 4'd0;
      end else begin
        if (w_busy & spi_wvld) begin
          r_drop <= 1'b1;
        end
        if (w_collision & (r_coll != 4'hF)) begin
          r_coll <= r_coll + 4'd1;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_flat
      assign regs_flat[g*REG_W +: REG_W] = r_bank[g];
    end
  endgenerate

  assign spi_rdata  = r_bank[spi_addr];
  assign core_gnt   = w_gnt;
  assign core_rdata = r_core_rdata;
  assign core_rvld  = r_core_rvld;
  assign status     = {w_busy, r_lock, r_drop, 1'b0, r_coll};

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Self-checking bench for reg_bank_ctrl: directed vector table, corner sequences,
// and random traffic compared against a countdown-based behavioural model.
module tb_reg_bank_ctrl;

  localparam int ADDR_W = 3;
  localparam int REG_W  = 8;
  localparam int DEPTH  = 8;

  logic        clk = 1'b0;
  logic        nrst;
  logic [2:0]  spi_addr;
  logic [7:0]  spi_wdata;
  logic        spi_wvld;
  logic [7:0]  spi_rdata;
  logic [5:0]  fastcmd;
  logic        fastcmd_vld;
  logic [7:0]  status;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_addr;
  logic [7:0]  core_wdata;
  logic        core_gnt;
  logic [7:0]  core_rdata;
  logic        core_rvld;
  logic [63:0] regs_flat;

  always #5 clk = ~clk;

  reg_bank_ctrl #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk(clk), .nrst(nrst),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wvld(spi_wvld), .spi_rdata(spi_rdata),
    .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld), .status(status),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvld(core_rvld),
    .regs_flat(regs_flat)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the clear is a countdown of remaining zero writes.
  logic [7:0] m_bank [DEPTH];
  int         m_clear_left;
  bit         m_lock;
  bit         m_drop;
  logic [3:0] m_coll;
  logic [7:0] m_rdata;
  bit         m_rvld;
  bit         m_gnt;

  function automatic bit m_busy();
    return m_clear_left > 0;
  endfunction

  function automatic logic [63:0] m_flat();
    logic [63:0] f;
    for (int i = 0; i < DEPTH; i++) f[i*8 +: 8] = m_bank[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bank[i] = 8'h00;
    m_clear_left = 0;
    m_lock = 1'b0; m_drop = 1'b0; m_coll = 4'd0;
    m_rdata = 8'h00; m_rvld = 1'b0; m_gnt = 1'b0;
  endtask

  task automatic check_model();
    m_gnt = core_req && !m_busy() && !spi_wvld;
    chk("gnt",       core_gnt,   m_gnt);
    chk("spi_rdata", spi_rdata,  m_bank[spi_addr]);
    chk("status",    status,     {m_busy(), m_lock, m_drop, 1'b0, m_coll});
    chk("rdata",     core_rdata, m_rdata);
    chk("rvld",      core_rvld,  m_rvld);
    chk("regs_flat", regs_flat,  m_flat());
  endtask

  task automatic model_step();
    bit         busy;
    bit         rd;
    logic [7:0] old_rd;
    busy   = m_busy();
    rd     = m_gnt && !core_we;
    old_rd = m_bank[core_addr];
    if (busy) m_bank[DEPTH - m_clear_left] = 8'h00;
    else if (spi_wvld) m_bank[spi_addr] = spi_wdata;
    else if (m_gnt && core_we && !m_lock) m_bank[core_addr] = core_wdata;
    m_rvld = rd;
    if (rd) m_rdata = old_rd;
    if (fastcmd_vld && fastcmd == 6'h01) m_clear_left = DEPTH;
    else if (busy) m_clear_left = m_clear_left - 1;
    if (fastcmd_vld && fastcmd == 6'h02) m_lock = 1'b1;
    else if (fastcmd_vld && fastcmd == 6'h03) m_lock = 1'b0;
    if (fastcmd_vld && fastcmd == 6'h04) begin
      m_drop = 1'b0;
      m_coll = 4'd0;
    end else begin
      if (busy && spi_wvld) m_drop = 1'b1;
      if (core_req && spi_wvld && m_coll != 4'hF) m_coll = m_coll + 4'd1;
    end
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    spi_wvld = 1'b0; spi_addr = 3'd0; spi_wdata = 8'h00;
    fastcmd_vld = 1'b0; fastcmd = 6'h00;
    core_req = 1'b0; core_we = 1'b0; core_addr = 3'd0; core_wdata = 8'h00;
  endtask

  typedef struct {
    logic       wv;  logic [2:0] sa;  logic [7:0] sd;
    logic       fv;  logic [5:0] fc;
    logic       rq;  logic       we;  logic [2:0] ca; logic [7:0] cd;
    logic       egnt; logic [7:0] esr; logic [7:0] est; logic erv; logic [7:0] erd;
  } vec_t;

  function automatic vec_t mkv(
    input logic wv, input logic [2:0] sa, input logic [7:0] sd,
    input logic fv, input logic [5:0] fc,
    input logic rq, input logic we, input logic [2:0] ca, input logic [7:0] cd,
    input logic egnt, input logic [7:0] esr, input logic [7:0] est,
    input logic erv, input logic [7:0] erd);
    vec_t v;
    v.wv = wv; v.sa = sa; v.sd = sd; v.fv = fv; v.fc = fc;
    v.rq = rq; v.we = we; v.ca = ca; v.cd = cd;
    v.egnt = egnt; v.esr = esr; v.est = est; v.erv = erv; v.erd = erd;
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    int  busy_cycles;
    bit  gnt_seen;
    bit  busy_at_gnt;

    tbl[0]  = mkv(1'b1,3'd3,8'hA5, 1'b0,6'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,8'h00,8'h00,1'b0,8'h00);
    tbl[1]  = mkv(1'b0,3'd3,8'h00, 1'b0,6'h00, 1'b1,1'b0,3'd3,8'h00, 1'b1,8'hA5,8'h00,1'b0,8'h00);
    tbl[2]  = mkv(1'b0,3'd3,8'h00, 1'b0,6'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,8'hA5,8'h00,1'b1,8'hA5);
    tbl[3]  = mkv(1'b1,3'd5,8'h77, 1'b0,6'h00, 1'b1,1'b1,3'd5,8'h3C, 1'b0,8'h00,8'h00,1'b0,8'hA5);
    tbl[4]  = mkv(1'b0,3'd5,8'h00, 1'b0,6'h00, 1'b1,1'b1,3'd5,8'h3C, 1'b1,8'h77,8'h01,1'b0,8'hA5);
    tbl[5]  = mkv(1'b0,3'd5,8'h00, 1'b0,6'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,8'h3C,8'h01,1'b0,8'hA5);
    tbl[6]  = mkv(1'b0,3'd5,8'h00, 1'b1,6'h04, 1'b0,1'b0,3'd0,8'h00, 1'b0,8'h3C,8'h01,1'b0,8'hA5);
    tbl[7]  = mkv(1'b0,3'd0,8'h00, 1'b1,6'h02, 1'b0,1'b0,3'd0,8'h00, 1'b0,8'h00,8'h00,1'b0,8'hA5);
    tbl[8]  = mkv(1'b0,3'd0,8'h00, 1'b0,6'h00, 1'b1,1'b1,3'd0,8'h11, 1'b1,8'h00,8'h40,1'b0,8'hA5);
    tbl[9]  = mkv(1'b0,3'd0,8'h00, 1'b1,6'h03, 1'b0,1'b0,3'd0,8'h00, 1'b0,8'h00,8'h40,1'b0,8'hA5);
    tbl[10] = mkv(1'b0,3'd0,8'h00, 1'b0,6'h00, 1'b1,1'b1,3'd0,8'h11, 1'b1,8'h00,8'h00,1'b0,8'hA5);
    tbl[11] = mkv(1'b0,3'd0,8'h00, 1'b0,6'h00, 1'b0,1'b0,3'd0,8'h00, 1'b0,8'h11,8'h00,1'b0,8'hA5);

    nrst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    settle();
    chk("reset_status", status, 8'h00);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      spi_wvld = tbl[i].wv; spi_addr = tbl[i].sa; spi_wdata = tbl[i].sd;
      fastcmd_vld = tbl[i].fv; fastcmd = tbl[i].fc;
      core_req = tbl[i].rq; core_we = tbl[i].we; core_addr = tbl[i].ca; core_wdata = tbl[i].cd;
      settle();
      chk($sformatf("row%0d_gnt", i),       core_gnt,   tbl[i].egnt);
      chk($sformatf("row%0d_spi_rdata", i), spi_rdata,  tbl[i].esr);
      chk($sformatf("row%0d_status", i),    status,     tbl[i].est);
      chk($sformatf("row%0d_rvld", i),      core_rvld,  tbl[i].erv);
      chk($sformatf("row%0d_rdata", i),     core_rdata, tbl[i].erd);
      advance();
    end
    idle_inputs();

    // Fill with FF, clear, SPI write during clear, core read waiting on busy
    for (int a = 0; a < DEPTH; a++) begin
      spi_wvld = 1'b1; spi_addr = 3'(a); spi_wdata = 8'hFF;
      settle();
      advance();
    end
    idle_inputs();
    settle();
    chk("filled_flat", regs_flat, 64'hFFFF_FFFF_FFFF_FFFF);
    fastcmd_vld = 1'b1; fastcmd = 6'h01;
    advance();
    idle_inputs();
    busy_cycles = 0;
    gnt_seen    = 1'b0;
    busy_at_gnt = 1'b1;
    for (int k = 0; k < 30; k++) begin
      core_req = 1'b1; core_we = 1'b0; core_addr = 3'd6;
      spi_wvld = (k == 2); spi_addr = 3'd1; spi_wdata = 8'h5A;
      settle();
      if (status[7]) begin
        busy_cycles++;
        chk("gnt_during_busy", core_gnt, 1'b0);
      end
      if (core_gnt) begin
        gnt_seen    = 1'b1;
        busy_at_gnt = status[7];
      end
      advance();
      if (gnt_seen) break;
    end
    idle_inputs();
    chk("clear_busy_cycles", busy_cycles, 8);
    chk("clear_gnt_seen", gnt_seen, 1'b1);
    chk("clear_gnt_after_busy", busy_at_gnt, 1'b0);
    settle();
    chk("clear_flat_zero", regs_flat, 64'h0);
    chk("drop_flag", status[5], 1'b1);
    fastcmd_vld = 1'b1; fastcmd = 6'h04;
    advance();
    idle_inputs();
    settle();
    chk("clrst_status", status, 8'h00);

    // Collision counter saturation
    for (int k = 0; k < 20; k++) begin
      core_req = 1'b1; core_we = 1'b1; core_addr = 3'd7; core_wdata = 8'hAA;
      spi_wvld = 1'b1; spi_addr = 3'd7; spi_wdata = 8'h55;
      settle();
      advance();
    end
    spi_wvld = 1'b0;
    settle();
    chk("coll_saturated", status[3:0], 4'hF);
    advance();
    idle_inputs();

    // Asynchronous reset in the middle of a clear
    fastcmd_vld = 1'b1; fastcmd = 6'h01;
    settle();
    advance();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      settle();
      advance();
    end
    settle();
    chk("busy_before_reset", status[7], 1'b1);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_status", status, 8'h00);
    chk("arst_flat", regs_flat, 64'h0);
    chk("arst_rdata", core_rdata, 8'h00);
    chk("arst_rvld", core_rvld, 1'b0);
    chk("arst_spi_rdata", spi_rdata, 8'h00);
    chk("arst_gnt", core_gnt, 1'b0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd2;
    settle();
    chk("idle_after_reset_gnt", core_gnt, 1'b1);
    advance();
    idle_inputs();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      spi_wvld    = ($urandom_range(0, 3) == 0);
      spi_addr    = 3'($urandom_range(0, 7));
      spi_wdata   = 8'($urandom_range(0, 255));
      fastcmd_vld = ($urandom_range(0, 15) == 0);
      fastcmd     = 6'($urandom_range(0, 7));
      if (!core_req && $urandom_range(0, 2) == 0) begin
        core_req   = 1'b1;
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = 3'($urandom_range(0, 7));
        core_wdata = 8'($urandom_range(0, 255));
      end
      settle();
      advance();
      if (m_gnt) core_req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_ctrl.md
# reg_bank_ctrl

Register-bank controller that owns the 2^ADDR_W x REG_W configuration registers behind the SPI register slave, and shares them between that SPI host port and an internal core requester. It applies SPI write pulses with absolute priority and arbitrates core read/write requests through a req/gnt handshake. It executes SPI fast commands (clear, lock, unlock, clear-status) and returns an 8-bit status byte that the SPI slave shifts out at the start of every frame.

## Interface
Parameters:
- ADDR_W, 3, register address width; bank depth is 2^ADDR_W.
- REG_W, 8, register width in bits; multiple of 8.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- spi_addr  in  ADDR_W  SPI-side register address.
- spi_wdata  in  REG_W  SPI write data.
- spi_wvld  in  1  one-cycle SPI write strobe.
- spi_rdata  out  REG_W  combinational read of bank[spi_addr].
- fastcmd  in  6  fast-command code.
- fastcmd_vld  in  1  one-cycle fast-command strobe.
- status  out  8  status byte to SPI slave.
- core_req  in  1  core access request; held until granted.
- core_we  in  1  1 = write, 0 = read; stable while core_req.
- core_addr  in  ADDR_W  core address; stable while core_req.
- core_wdata  in  REG_W  core write data; stable while core_req.
- core_gnt  out  1  combinational grant; access completes this cycle.
- core_rdata  out  REG_W  registered read data.
- core_rvld  out  1  one-cycle pulse, cycle after a granted read.
- regs_flat  out  2^ADDR_W*REG_W  all registers, reg 0 in LSBs, for direct use by design logic.

## Operation
- FSM states: IDLE, CLEAR. Reset -> IDLE.
- IDLE -> CLEAR on fastcmd_vld with fastcmd = 6'h01. CLEAR writes zero to addresses 0..2^ADDR_W-1, one per cycle, using a clr_ptr of width ADDR_W. CLEAR -> IDLE after the address 2^ADDR_W-1 write. A new 6'h01 during CLEAR restarts clr_ptr at 0.
- SPI write: when spi_wvld is high in IDLE, bank[spi_addr] <= spi_wdata. When spi_wvld is high in CLEAR, the write is dropped and the sticky drop flag is set.
- core_gnt = core_req and state == IDLE and !spi_wvld.
- Granted write: bank[core_addr] <= core_wdata, except when lock = 1. In that case the write is granted but discarded, so the core never deadlocks.
- Granted read: core_rdata <= bank[core_addr]; core_rvld pulses on the next cycle. core_rdata holds its value otherwise.
- Collision counter: a 4-bit counter increments, saturating at 15, on every cycle where core_req and spi_wvld are both high.
- Fast commands:
  - 6'h01 clear.
  - 6'h02 lock = 1.
  - 6'h03 lock = 0.
  - 6'h04 clears the drop flag and the collision counter.
  - All other codes are ignored.
  - Lock and unlock are also honoured during CLEAR.
- Status byte: [7] busy (state == CLEAR), [6] lock, [5] drop sticky, [4] 0, [3:0] collision count.
- Reset values: every register, core_rdata, core_rvld, lock, drop, counter and clr_ptr = 0; state = IDLE; status = 8'h00. core_gnt = 0 because no request is pending.

## Timing
- SPI write at cycle N: visible on spi_rdata and regs_flat at N+1.
- Core write granted at N: visible at N+1.
- Core read granted at N: core_rdata and core_rvld valid at N+1.
- Clear strobe at N: busy rises at N+1; zero writes happen at N+1..N+2^ADDR_W. busy falls at N+2^ADDR_W+1; the first core grant is possible in that same cycle.
- Same-cycle spi_wvld and fastcmd_vld (6'h01): the SPI write is applied and the clear starts next cycle, so the clear wins.
- Same-cycle spi_wvld and core write to the same address: the SPI value is stored; the core is stalled and completes on a later cycle, overwriting it.
- Fastcmd 6'h04 coinciding with a collision: the clear wins and the counter reads 0.
- Asynchronous reset mid-CLEAR: returns immediately to IDLE with all reset values.

## Test plan
- Reset, then SPI write 8'hA5 to address 3 -> spi_rdata = 8'hA5 one cycle later with spi_addr = 3; core read of address 3 -> core_rvld with core_rdata = 8'hA5.
- Core write 8'h3C to address 5 held, with spi_wvld pulsed in the same cycle -> core_gnt = 0 that cycle, 1 the next; status[3:0] = 1; bank[5] = 8'h3C.
- Fill all registers with 8'hFF, then fastcmd 6'h01 -> status[7] high for exactly 8 cycles (ADDR_W = 3); regs_flat = 0 afterwards; core_req during clear is granted only after busy falls.
- SPI write during clear -> write dropped; status[5] = 1. Then fastcmd 6'h04 -> status = 8'h00.
- fastcmd 6'h02, then core write 8'h11 to address 0 -> granted, bank[0] unchanged, status[6] = 1. Then fastcmd 6'h03 and a repeat write -> bank[0] = 8'h11.
- Hold core_req and spi_wvld together for 20 cycles -> status[3:0] saturates at 4'hF. Assert nrst mid-clear -> all outputs 0 and state IDLE.
